// File: rtl/ysyx_23060096_rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Default widths, the x0 address and the requester slot indices.
package ysyx_23060096_rf_wb_arbiter_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   // Writes to x0 are accepted but never reach the register file.
   localparam int X0_ADDR = 0;

   localparam int REQ_ALU = 0;
   localparam int REQ_LSU = 1;
   localparam int REQ_CSR = 2;

endpackage

// File: rtl/ysyx_23060096_rr_arbiter.sv
// NREQ-wide round-robin arbiter with its own rotating pointer.
// Ports: clk, rstn, valid (requests), grant (one-hot, only on valid).
module ysyx_23060096_rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] valid,
   output logic [NREQ-1:0] grant
);

   localparam int IW = $clog2(NREQ);

   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nxt;
   logic          found;
   int            idx;

   // Search starts at ptr and wraps; first valid slot wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // Grant implies valid, so any grant is a completed handshake.
   always_comb begin
      ptr_nxt = ptr;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            ptr_nxt = (i + 1 == NREQ) ? '0 : IW'(i + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ptr <= '0;
      else       ptr <= ptr_nxt;
   end

endmodule

// File: rtl/ysyx_23060096_rf_wb_arbiter.sv
// Register-file write-port arbiter plus pending-write scoreboard.
// Ports: req_* handshakes in, rf_* registered write out,
// sb_* scoreboard control, busy_a/b hazard flags, sb_err sticky.
module ysyx_23060096_rf_wb_arbiter
   import ysyx_23060096_rf_wb_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W_DEF,
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int NREQ       = 3
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ*DATA_WIDTH-1:0] req_data,
   output logic                       rf_w_en,
   output logic [ADDR_WIDTH-1:0]      rf_waddr,
   output logic [DATA_WIDTH-1:0]      rf_wdata,
   input  logic                       sb_set_en,
   input  logic [ADDR_WIDTH-1:0]      sb_set_addr,
   input  logic                       sb_flush,
   input  logic [ADDR_WIDTH-1:0]      rd_addr_a,
   input  logic [ADDR_WIDTH-1:0]      rd_addr_b,
   output logic                       busy_a,
   output logic                       busy_b,
   output logic                       sb_err
);

   localparam int NREG = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_ADDR);

   logic                  hs;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [NREG-1:0]       pend;
   logic [NREG-1:0]       pend_nxt;
   logic                  set_ok;
   logic                  set_bad;

   ysyx_23060096_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .valid (req_valid),
      .grant (req_ready)
   );

   assign hs = |req_ready;

   // One-hot grant makes an OR-mux sufficient.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i]) begin
            sel_addr = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rf_w_en  <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_w_en <= hs && (sel_addr != X0);
         if (hs) begin
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
         end
      end
   end

   assign set_ok  = sb_set_en && (sb_set_addr != X0);
   assign set_bad = set_ok && pend[sb_set_addr];

   // Clear then set, so a new producer beats the retiring one.
   always_comb begin
      pend_nxt = pend;
      if (rf_w_en) pend_nxt[rf_waddr] = 1'b0;
      if (set_ok)  pend_nxt[sb_set_addr] = 1'b1;
      if (sb_flush) pend_nxt = '0;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend   <= '0;
         sb_err <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (set_bad) sb_err <= 1'b1;
      end
   end

   assign busy_a = pend[rd_addr_a];
   assign busy_b = pend[rd_addr_b];

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_arbiter.sv
// Random plus directed bench for the writeback arbiter.
// Checks every cycle against an array-based reference model.
module tb_ysyx_23060096_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic            rf_w_en;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic            sb_set_en = 1'b0;
   logic [AW-1:0]   sb_set_addr = '0;
   logic            sb_flush = 1'b0;
   logic [AW-1:0]   rd_addr_a = '0;
   logic [AW-1:0]   rd_addr_b = '0;
   logic            busy_a;
   logic            busy_b;
   logic            sb_err;

   int total = 0;
   int bad   = 0;

   int        m_ptr;
   bit        m_wen;
   bit [4:0]  m_waddr;
   bit [31:0] m_wdata;
   bit [31:0] m_pend;
   bit        m_err;

   ysyx_23060096_rf_wb_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NREQ       (N)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rf_w_en     (rf_w_en),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .sb_flush    (sb_flush),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .sb_err      (sb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_wen   = 0;
      m_waddr = 0;
      m_wdata = 0;
      m_pend  = 0;
      m_err   = 0;
   endtask

   function automatic int model_grant(input logic [N-1:0] v);
      int g;
      g = -1;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      return g;
   endfunction

   task automatic drive(input logic [N-1:0] v,
                        input logic [N*AW-1:0] a,
                        input logic [N*DW-1:0] d,
                        input logic se, input logic [AW-1:0] sa,
                        input logic fl,
                        input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb);
      @(negedge clk);
      req_valid   = v;
      req_addr    = a;
      req_data    = d;
      sb_set_en   = se;
      sb_set_addr = sa;
      sb_flush    = fl;
      rd_addr_a   = ra;
      rd_addr_b   = rb;
   endtask

   // Compare combinational outputs, clock, advance model, compare regs.
   task automatic step();
      int g;
      logic [N-1:0] er;
      bit [31:0] old;
      #1;
      g  = model_grant(req_valid);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      check("ready", 64'(req_ready), 64'(er));
      check("busy_a", 64'(busy_a), 64'(m_pend[rd_addr_a]));
      check("busy_b", 64'(busy_b), 64'(m_pend[rd_addr_b]));
      @(posedge clk);
      old = m_pend;
      if (m_wen) m_pend[m_waddr] = 0;
      if (sb_set_en && sb_set_addr != 0) begin
         if (old[sb_set_addr]) m_err = 1;
         m_pend[sb_set_addr] = 1;
      end
      if (sb_flush) m_pend = 0;
      if (g >= 0) begin
         m_wen   = (req_addr[g*AW +: AW] != 0);
         m_waddr = req_addr[g*AW +: AW];
         m_wdata = req_data[g*DW +: DW];
         m_ptr   = (g + 1) % N;
      end else begin
         m_wen = 0;
      end
      #1;
      check("w_en", 64'(rf_w_en), 64'(m_wen));
      if (m_wen) begin
         check("waddr", 64'(rf_waddr), 64'(m_waddr));
         check("wdata", 64'(rf_wdata), 64'(m_wdata));
      end
      check("sb_err", 64'(sb_err), 64'(m_err));
   endtask

   task automatic idle();
      drive('0, '0, '0, 0, 0, 0, rd_addr_a, rd_addr_b);
      step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 0;
      req_valid = '0;
      sb_set_en = 0;
      sb_flush  = 0;
      model_reset();
      #1;
      check("rst_w_en", 64'(rf_w_en), 64'(0));
      check("rst_err", 64'(sb_err), 64'(0));
      @(negedge clk);
      rstn = 1;
   endtask

   initial begin
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      model_reset();
      rd_addr_a = 0;
      rd_addr_b = 0;
      #12;
      check("rst_busy_a", 64'(busy_a), 64'(0));
      check("rst_busy_b", 64'(busy_b), 64'(0));
      check("rst_wen0", 64'(rf_w_en), 64'(0));
      @(negedge clk);
      rstn = 1;
      idle();

      // single request on slot 1
      a = '0; d = '0;
      a[1*AW +: AW] = 5;
      d[1*DW +: DW] = 32'hDEADBEEF;
      drive(3'b010, a, d, 0, 0, 0, 0, 0);
      #1;
      check("single_rdy", 64'(req_ready), 64'(3'b010));
      step();
      check("single_data", 64'(rf_wdata), 64'(32'hDEADBEEF));
      idle();

      // round robin with all valid
      a = {5'd3, 5'd2, 5'd1};
      for (int c = 0; c < 6; c++) begin
         d = {32'(c + 300), 32'(c + 200), 32'(c + 100)};
         drive(3'b111, a, d, 0, 0, 0, 0, 0);
         step();
      end
      idle();

      // scoreboard set / clear / same-edge set
      drive(3'b000, '0, '0, 1, 7, 0, 7, 0);
      step();
      check("sb_busy7", 64'(busy_a), 64'(1));
      a = '0; d = '0;
      a[2*AW +: AW] = 7;
      d[2*DW +: DW] = 32'h1234;
      drive(3'b100, a, d, 0, 0, 0, 7, 0);
      step();
      drive(3'b000, '0, '0, 1, 7, 0, 7, 0);
      step();
      check("sb_set_wins", 64'(busy_a), 64'(1));
      do_reset();

      // x0 request and illegal set
      a = '0; d = '0;
      d[0 +: DW] = 32'hFFFF;
      drive(3'b001, a, d, 1, 3, 0, 3, 0);
      step();
      drive(3'b000, '0, '0, 1, 3, 0, 3, 0);
      step();
      check("err_sticky", 64'(sb_err), 64'(1));
      idle();
      idle();

      // flush with 4 and 9 pending
      drive(3'b000, '0, '0, 1, 4, 0, 4, 9);
      step();
      drive(3'b000, '0, '0, 1, 9, 0, 4, 9);
      step();
      drive(3'b000, '0, '0, 0, 0, 1, 4, 9);
      step();
      check("flush_a", 64'(busy_a), 64'(0));
      check("flush_b", 64'(busy_b), 64'(0));

      // reset with write in flight
      a = '0; d = '0;
      a[0 +: AW] = 11;
      d[0 +: DW] = 32'h55;
      drive(3'b001, a, d, 0, 0, 0, 0, 0);
      step();
      rstn = 0;
      model_reset();
      #1;
      check("midrst_wen", 64'(rf_w_en), 64'(0));
      req_valid = 3'b010;
      #1;
      check("rst_ready", 64'(req_ready), 64'(3'b010));
      @(negedge clk);
      req_valid = '0;
      rstn = 1;

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if (c % 150 == 149) do_reset();
         for (int i = 0; i < N; i++) begin
            a[i*AW +: AW] = AW'($urandom_range(0, 7));
            d[i*DW +: DW] = $urandom;
         end
         drive(N'($urandom),
               a, d,
               ($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 7)),
               ($urandom_range(0, 31) == 0),
               AW'($urandom_range(0, 7)),
               AW'($urandom_range(0, 7)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_23060096_rf_wb_arbiter.md
# ysyx_23060096_rf_wb_arbiter

Shares the single register-file write port between several writeback requesters (ALU, LSU, CSR unit) using round-robin arbitration with valid/ready handshakes. It also keeps a per-register pending-write scoreboard so the issue stage can stall on read-after-write hazards. It sits between the execute/memory units and the register file write port (w_en/waddr/wdata).

## Interface
- ADDR_WIDTH, 5: register address width; register count = 1<<ADDR_WIDTH.
- DATA_WIDTH, 32: write data width.
- NREQ, 3: number of writeback requesters; legal range 2..8.

- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i is granted this cycle.
- req_addr  in  NREQ*ADDR_WIDTH  slot i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NREQ*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH].
- rf_w_en  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).
- sb_set_en  in  1  issue stage marks a destination as pending.
- sb_set_addr  in  ADDR_WIDTH  destination to mark.
- sb_flush  in  1  clear all pending bits (pipeline flush).
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH each  source operands to check.
- busy_a, busy_b  out  1 each  operand has a pending write (combinational from scoreboard).
- sb_err  out  1  sticky: set on an illegal scoreboard set.

## Operation
- Arbiter: round-robin pointer ptr (0..NREQ-1). Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … modulo NREQ. At most one req_ready bit is high. A requester with req_valid low never sees req_ready high.
- Handshake: req_valid[i] & req_ready[i] at an edge means accepted. ptr becomes (i+1) mod NREQ. With no handshake, ptr holds.
- The output stage always accepts one write per cycle, so req_ready is purely the grant and never waits on downstream.
- Write stage: on handshake, rf_w_en<=1, rf_waddr<=addr_i, rf_wdata<=data_i. With no handshake, rf_w_en<=0 and addr/data hold.
- x0: a request with address 0 is accepted and advances ptr. rf_w_en stays 0 for it, and no scoreboard clear is issued.
- Scoreboard: pend[1<<ADDR_WIDTH] bits. Bit 0 is hard-wired 0.
  - Set: sb_set_en with nonzero addr sets pend[addr].
  - Clear: pend[rf_waddr] clears at the edge where rf_w_en=1.
- Same-edge set and clear of the same address: set wins (new producer), so the bit stays 1.
- Set on an already-pending register is illegal. The bit stays 1 and sb_err latches 1 until reset.
- sb_flush clears all pend bits, overriding sets and clears in that cycle. It does not cancel the arbiter or the write-stage register.
- busy_a = pend[rd_addr_a] and busy_b = pend[rd_addr_b]; address 0 always reads 0.

## Timing
- Reset (async assert, sync deassert by the system): ptr=0, rf_w_en=0, rf_waddr=0, rf_wdata=0, all pend=0, sb_err=0.
  - req_ready follows req_valid combinationally even during reset, but nothing is accepted while rstn=0.
- Latency: handshake at edge T puts rf_w_en high during cycle T..T+1. The register file writes at edge T+1. pend clears at T+1, so busy falls in the first cycle the register file holds the new value.
- Throughput: one write per cycle sustained. With all requesters continuously valid, each is served exactly once every NREQ cycles.
- Reset asserted mid-operation drops the in-flight write (rf_w_en forced 0 immediately).

## Structure
- Shared package/header: ADDR_WIDTH and DATA_WIDTH defaults, the x0 address constant, and requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_CSR=2).
- One natural sub-module: ysyx_23060096_rr_arbiter (NREQ-wide round-robin grant plus pointer). It can be reused later for memory-port sharing.
- The scoreboard and write-stage registers live in the top module.

## Test plan
- Reset: release rstn with all inputs 0 -> rf_w_en=0, busy_a/b=0, sb_err=0, ptr=0.
- Single request: req_valid=3'b010, addr 5, data 0xDEADBEEF -> req_ready=3'b010. The next cycle has rf_w_en=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Round-robin: req_valid=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2, with rf_w_en high every cycle.
- Scoreboard: set reg 7, rd_addr_a=7 -> busy_a=1. Then a write to reg 7 via requester 2 -> busy_a=0 the cycle after rf_w_en=1 for addr 7. Issuing a set on 7 in that same clearing cycle keeps busy_a=1.
- x0 and error: a request to addr 0 -> req_ready=1, rf_w_en stays 0. sb_set_en to an already-pending reg 3 -> sb_err=1, sticky until reset.
- Flush and reset: with regs 4 and 9 pending, pulse sb_flush -> both busy 0 next cycle. Asserting rstn low while rf_w_en=1 -> rf_w_en=0 immediately.
